load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, data memory depth in 32-bit words; SHALL be a power of two.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 mem_read_en  input  1  load request from control unit; held stable by pipeline while stall=1.
REQ-005 mem_write_en  input  1  store request from control unit.
REQ-006 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address from ALU.
REQ-008 wdata  input  32  store data; low byte/half used for SB/SH.
REQ-009 rdata  output  32  registered, extended load result.
REQ-010 rdata_valid  output  1  one-cycle pulse, rdata holds the load result.
REQ-011 stall  output  1  combinational; pipeline SHALL hold the memory stage while high.
REQ-012 misalign_trap  output  1  one-cycle pulse on a misaligned access.

Function
REQ-013 FSM states: IDLE, LOAD_WAIT, LOAD_RESP.
REQ-014 Load: IDLE + mem_read_en in cycle N -> SRAM read issued at N, go to LOAD_WAIT; LOAD_WAIT (N+1) -> capture and extend SRAM word into rdata, go to LOAD_RESP; LOAD_RESP (N+2) -> rdata_valid=1, go to IDLE.
REQ-015 stall SHALL be 1 in cycle N (IDLE with valid load) and N+1, and 0 in N+2.
REQ-016 In LOAD_RESP, mem_read_en/mem_write_en SHALL be ignored; they still present the completing load.
REQ-017 Store: IDLE + mem_write_en -> SRAM write at the cycle-end edge with byte enables; no stall; FSM stays IDLE.
REQ-018 Byte lane: SB writes byte addr[1:0], SH writes half addr[1], SW writes all four bytes; other bytes unchanged.
REQ-019 Load extension: LB/LH sign-extend, LBU/LHU zero-extend the selected lane; LW returns the whole word.
REQ-020 mem_read_en and mem_write_en both high: load executes, store dropped.
REQ-021 Invalid funct3 (011, 110, 111; any 1xx for stores): no SRAM write; loads complete normally with rdata=0.
REQ-022 Word index = addr[2+:log2(DEPTH_WORDS)]; upper address bits ignored (wrap modulo depth).
REQ-023 rdata SHALL hold its last value outside LOAD_RESP.

Reset
REQ-024 reset SHALL force IDLE, rdata=0, rdata_valid=0, stall=0, misalign_trap=0 at the next edge, including mid-load; the pending load is dropped.
REQ-025 reset SHALL NOT clear memory contents.
REQ-026 A store asserted in the same cycle as reset SHALL NOT write.

Configuration
REQ-027 Macro LSU_MISALIGN_TRAP_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=0 performs no SRAM access, pulses misalign_trap in the request cycle, keeps stall=0, keeps FSM in IDLE, and produces no rdata_valid.
REQ-028 Macro undefined: misalign_trap tied 0; misaligned addresses aligned down (half: addr[0] ignored; word: addr[1:0] ignored) and the access completes normally.

Structure
REQ-029 Package lsu_pkg SHALL hold funct3 encoding constants, the FSM state enum, and the byte-enable width constant.
REQ-030 Sub-module dmem_sram: single-port, synchronous, 32-bit words with 4 byte enables, 1-cycle read latency; load_store_unit instantiates it.

Verification
REQ-031 SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> stall high 2 cycles, rdata_valid in 3rd cycle, rdata=0xDEADBEEF.
REQ-032 After REQ-031, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-033 SB addr=0x11 wdata=0x00000055 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF.
REQ-034 LW 0x10 issued, reset asserted in LOAD_WAIT -> next cycle stall=0, rdata_valid stays 0, rdata=0, FSM IDLE; memory word still readable.
REQ-035 With LSU_MISALIGN_TRAP_EN: SW 0x12 -> misalign_trap=1 for one cycle, memory unchanged; LH 0x11 -> trap, no stall, no rdata_valid. Without the macro: LW 0x13 returns word 0x10.
REQ-036 Both enables high, funct3=010, addr=0x20 -> load of 0x20 returned, memory at 0x20 unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store unit shared types, funct3 encodings and lane helpers
package lsu_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, LOAD_RESP} lsu_state_t;

  function automatic logic [BE_W-1:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    store_be = 4'b0001 << off;
      F3_H:    store_be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_BU:   load_extend = {24'd0, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_HU:   load_extend = {16'd0, h};
      F3_W:    load_extend = word;
      default: load_extend = 32'd0;
    endcase
  endfunction

  // Stores only recognise the unsigned-free encodings, so HU never traps as a store.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off,
                                         input logic is_load);
    logic half;
    half = (f3[1:0] == 2'b01) && (is_load || !f3[2]);
    is_misaligned = (half && off[0]) || ((f3 == F3_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - single-port synchronous data SRAM, byte-enabled writes, 1-cycle read
module dmem_sram
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [BE_W-1:0] be,
  input  logic [AW-1:0]   idx,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit; LSU_MISALIGN_TRAP_EN enables misalign traps
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        stall,
  output logic        misalign_trap
);

  localparam int AW = $clog2(DEPTH_WORDS);

  lsu_state_t      state;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            idle_req;
  logic            misaligned;
  logic            load_go;
  logic            store_go;
  logic [BE_W-1:0] be;
  logic [31:0]     sram_wdata;
  logic [31:0]     sram_rdata;
  logic            addr_unused;

  assign idle_req = (state == IDLE) && (mem_read_en || mem_write_en);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = idle_req && is_misaligned(funct3, addr[1:0], mem_read_en);
`else
  assign misaligned = 1'b0;
`endif

  assign misalign_trap = misaligned;
  assign load_go       = (state == IDLE) && mem_read_en && !misaligned;
  // A simultaneous load wins the single port, and reset suppresses the write.
  assign store_go      = (state == IDLE) && mem_write_en && !mem_read_en && !misaligned && !reset;
  assign be            = store_go ? store_be(funct3, addr[1:0]) : '0;
  assign stall         = load_go || (state == LOAD_WAIT);
  assign addr_unused   = ^addr;

  always_comb begin
    sram_wdata = wdata;
    case (funct3[1:0])
      2'b00:   sram_wdata = {4{wdata[7:0]}};
      2'b01:   sram_wdata = {2{wdata[15:0]}};
      default: sram_wdata = wdata;
    endcase
  end

  dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_dmem (
    .clk   (clk),
    .en    (load_go || store_go),
    .we    (store_go),
    .be    (be),
    .idx   (addr[2 +: AW]),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rdata       <= 32'd0;
      rdata_valid <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          rdata_valid <= 1'b0;
          if (load_go) begin
            state <= LOAD_WAIT;
            f3_q  <= funct3;
            off_q <= addr[1:0];
          end
        end
        LOAD_WAIT: begin
          rdata       <= load_extend(f3_q, off_q, sram_rdata);
          rdata_valid <= 1'b1;
          state       <= LOAD_RESP;
        end
        LOAD_RESP: begin
          rdata_valid <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          rdata_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        stall;
  logic        misalign_trap;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_WORDS(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .stall        (stall),
    .misalign_trap(misalign_trap)
  );

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write_en = 1'b1; mem_read_en = 1'b0; funct3 = f3; addr = a; wdata = d;
    #1;
    tests++;
    if (stall !== 1'b0 || misalign_trap !== 1'b0) begin
      fails++;
      $display("FAIL store_flags a=%h stall=%b trap=%b required 0/0", a, stall, misalign_trap);
    end
    @(negedge clk);
    mem_write_en = 1'b0;
  endtask

  // Issues a load (optionally with a concurrent store) and checks stall length and result.
  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic we,
                      input logic [31:0] d, input logic [31:0] expv);
    int  stalls;
    bit  got;
    logic [31:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    mem_read_en = 1'b1; mem_write_en = we; funct3 = f3; addr = a; wdata = d;
    stalls = 0; got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      #1;
      if (rdata_valid) begin
        got = 1;
        e = exp_q.pop_front();
        tests++;
        if (rdata !== e) begin
          fails++;
          $display("FAIL load_data f3=%b a=%h got=%h required=%h", f3, a, rdata, e);
        end
        tests++;
        if (stall !== 1'b0) begin
          fails++;
          $display("FAIL resp_stall got=%b required=0", stall);
        end
        mem_read_en = 1'b0; mem_write_en = 1'b0;
      end else begin
        if (stall) stalls++;
        @(negedge clk);
      end
    end
    mem_read_en = 1'b0; mem_write_en = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      void'(exp_q.pop_front());
      $display("FAIL load_timeout a=%h no rdata_valid", a);
    end else if (stalls != 2) begin
      fails++;
      $display("FAIL stall_cycles a=%h got=%0d required=2", a, stalls);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_read_en = 0; mem_write_en = 0; funct3 = 0; addr = 0; wdata = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (rdata !== 32'd0 || rdata_valid !== 1'b0 || stall !== 1'b0 || misalign_trap !== 1'b0) begin
      fails++;
      $display("FAIL reset_state rdata=%h valid=%b stall=%b trap=%b required 0", rdata,
               rdata_valid, stall, misalign_trap);
    end
  endtask

  task automatic test_word;
    store(3'b010, 32'h10, 32'hDEADBEEF);
    load(3'b010, 32'h10, 0, 0, 32'hDEADBEEF);
  endtask

  task automatic test_extend;
    load(3'b000, 32'h13, 0, 0, 32'hFFFFFFDE);
    load(3'b100, 32'h13, 0, 0, 32'h000000DE);
    load(3'b001, 32'h12, 0, 0, 32'hFFFFDEAD);
    load(3'b101, 32'h10, 0, 0, 32'h0000BEEF);
    load(3'b000, 32'h10, 0, 0, 32'hFFFFFFEF);
  endtask

  task automatic test_partial_store;
    store(3'b000, 32'h11, 32'h00000055);
    load(3'b010, 32'h10, 0, 0, 32'hDEAD55EF);
    store(3'b010, 32'h14, 32'h00000000);
    store(3'b001, 32'h16, 32'h1234CAFE);
    load(3'b010, 32'h14, 0, 0, 32'hCAFE0000);
  endtask

  task automatic test_reset_mid_load;
    @(negedge clk);
    mem_read_en = 1'b1; funct3 = 3'b010; addr = 32'h10;
    @(negedge clk);
    reset = 1'b1; mem_read_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_load stall=%b valid=%b rdata=%h required 0/0/0", stall,
               rdata_valid, rdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests++;
      if (rdata_valid !== 1'b0) begin
        fails++;
        $display("FAIL dropped_load_valid got=%b required=0", rdata_valid);
      end
    end
    load(3'b010, 32'h10, 0, 0, 32'hDEAD55EF);
  endtask

  task automatic test_reset_store;
    store(3'b010, 32'h40, 32'hA5A5A5A5);
    @(negedge clk);
    reset = 1'b1; mem_write_en = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata = 32'h12345678;
    @(negedge clk);
    reset = 1'b0; mem_write_en = 1'b0;
    load(3'b010, 32'h40, 0, 0, 32'hA5A5A5A5);
  endtask

  task automatic test_both_enables;
    store(3'b010, 32'h20, 32'h11223344);
    load(3'b010, 32'h20, 1, 32'h99999999, 32'h11223344);
    load(3'b010, 32'h20, 0, 0, 32'h11223344);
  endtask

  task automatic test_invalid_and_wrap;
    store(3'b100, 32'h10, 32'h00000000);
    load(3'b010, 32'h10, 0, 0, 32'hDEAD55EF);
    load(3'b011, 32'h10, 0, 0, 32'h00000000);
    load(3'b110, 32'h10, 0, 0, 32'h00000000);
    store(3'b010, 32'h1010, 32'h0BADF00D);
    load(3'b010, 32'h10, 0, 0, 32'h0BADF00D);
  endtask

  task automatic test_misalign;
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    mem_write_en = 1'b1; funct3 = 3'b010; addr = 32'h12; wdata = 32'hFFFFFFFF;
    #1;
    tests++;
    if (misalign_trap !== 1'b1 || stall !== 1'b0) begin
      fails++;
      $display("FAIL sw_trap trap=%b stall=%b required 1/0", misalign_trap, stall);
    end
    @(negedge clk);
    mem_write_en = 1'b0;
    #1;
    tests++;
    if (misalign_trap !== 1'b0) begin
      fails++;
      $display("FAIL trap_pulse got=%b required=0", misalign_trap);
    end
    load(3'b010, 32'h10, 0, 0, 32'h0BADF00D);
    @(negedge clk);
    mem_read_en = 1'b1; funct3 = 3'b001; addr = 32'h11;
    #1;
    tests++;
    if (misalign_trap !== 1'b1 || stall !== 1'b0) begin
      fails++;
      $display("FAIL lh_trap trap=%b stall=%b required 1/0", misalign_trap, stall);
    end
    @(negedge clk);
    mem_read_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (rdata_valid !== 1'b0 || stall !== 1'b0) begin
        fails++;
        $display("FAIL lh_trap_noresp valid=%b stall=%b required 0/0", rdata_valid, stall);
      end
      @(negedge clk);
    end
`else
    load(3'b010, 32'h13, 0, 0, 32'h0BADF00D);
    load(3'b001, 32'h11, 0, 0, 32'hFFFFF00D);
    @(negedge clk);
    mem_read_en = 1'b1; funct3 = 3'b010; addr = 32'h12;
    #1;
    tests++;
    if (misalign_trap !== 1'b0) begin
      fails++;
      $display("FAIL trap_tied got=%b required=0", misalign_trap);
    end
    mem_read_en = 1'b0;
    repeat (3) @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_partial_store();
    test_reset_mid_load();
    test_reset_store();
    test_both_enables();
    test_invalid_and_wrap();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
